// File: rtl/pool_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pool_pkg
// Description : Shared types and elaboration helpers for the pooling unit.
//               Provides the pooling-mode enum, a constant clog2, a
//               power-of-two test and the accumulator-width helper.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package pool_pkg;

  typedef enum logic {
    POOL_MAX = 1'b0,
    POOL_AVG = 1'b1
  } pool_mode_e;

  // Smallest r with 2**r >= value (0 for value <= 1).
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

  // A POOLxPOOL sum needs 2*log2(POOL) guard bits above the sample width.
  function automatic int acc_width(input int data_w, input int pool);
    return data_w + 2 * clog2(pool);
  endfunction

endpackage : pool_pkg
`default_nettype wire

// File: rtl/pool_combine.sv
`default_nettype none
// ============================================================================
// Module      : pool_combine
// Description : Combinational window accumulator step. Produces the next
//               accumulator value from the stored partial result and the
//               incoming sample, for either max or average pooling.
// Ports       : mode_i     - pooling mode (max / average)
//               first_i    - sample is the first of its window (initialise)
//               acc_i      - stored partial result
//               in_i       - incoming sample
//               acc_next_o - updated partial result
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module pool_combine
  import pool_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 10,
  parameter bit SIGNED = 1'b1
) (
  input  pool_mode_e        mode_i,
  input  logic              first_i,
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [DATA_W-1:0] in_i,
  output logic [ACC_W-1:0]  acc_next_o
);

  localparam int PAD_W = ACC_W - DATA_W;

  logic [ACC_W-1:0]  w_in_ext;
  logic [DATA_W-1:0] w_acc_lo;
  logic              w_acc_wins;

  // In max mode the running maximum lives in the low DATA_W bits.
  assign w_acc_lo = acc_i[DATA_W-1:0];

  generate
    if (SIGNED) begin : g_signed
      assign w_in_ext   = {{PAD_W{in_i[DATA_W-1]}}, in_i};
      assign w_acc_wins = $signed(w_acc_lo) > $signed(in_i);
    end else begin : g_unsigned
      assign w_in_ext   = {{PAD_W{1'b0}}, in_i};
      assign w_acc_wins = w_acc_lo > in_i;
    end
  endgenerate

  always_comb begin
    acc_next_o = '0;
    if (mode_i == POOL_AVG) begin
      acc_next_o = first_i ? w_in_ext : (acc_i + w_in_ext);
    end else begin
      acc_next_o = {{PAD_W{1'b0}}, (!first_i && w_acc_wins) ? w_acc_lo : in_i};
    end
  end

endmodule : pool_combine
`default_nettype wire

// File: rtl/pool_unit_gen.sv
`default_nettype none
// ============================================================================
// Module      : pool_unit_gen
// Description : Streaming non-overlapping POOLxPOOL pooling stage for a
//               raster-order stream of CH-interleaved pixels. Runtime max or
//               average mode (latched on the first beat of each frame),
//               configurable signedness, trailing partial rows/cols dropped.
// Ports       : clk        - rising-edge clock
//               rst        - synchronous active-high reset
//               mode       - 0 = max, 1 = average (sampled at frame start)
//               in_valid   - input beat qualifier
//               in_data    - sample for the current (row, col, ch)
//               out_valid  - one-cycle pulse per pooled result
//               out_data   - pooled result
//               out_ch     - channel index of out_data
//               frame_done - pulse the cycle after the last beat of a frame
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module pool_unit_gen
  import pool_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int POOL   = 2,
  parameter int CH     = 1,
  parameter bit SIGNED = 1'b1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 mode,
  input  logic                                 in_valid,
  input  logic [DATA_W-1:0]                    in_data,
  output logic                                 out_valid,
  output logic [DATA_W-1:0]                    out_data,
  output logic [((CH > 1) ? clog2(CH) : 1)-1:0] out_ch,
  output logic                                 frame_done
);

  localparam int ACC_W   = acc_width(DATA_W, POOL);
  localparam int LOG_P   = clog2(POOL);
  localparam int SHIFT   = 2 * LOG_P;
  localparam int OUT_COLS = IMG_W / POOL;
  localparam int ACT_W   = OUT_COLS * POOL;
  localparam int ACT_H   = (IMG_H / POOL) * POOL;
  localparam int ENTRIES = OUT_COLS * CH;
  localparam int CH_W    = (CH > 1) ? clog2(CH) : 1;
  localparam int COL_W   = clog2(IMG_W);
  localparam int ROW_W   = clog2(IMG_H);
  localparam int IDX_W   = (ENTRIES > 1) ? clog2(ENTRIES) : 1;

  generate
    if (!is_pow2(POOL) || (POOL < 2) || (POOL > 8) ||
        (POOL > IMG_W) || (POOL > IMG_H)) begin : g_bad_pool
      $error("pool_unit_gen: POOL must be a power of two in 2..8 and not exceed IMG_W/IMG_H");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [CH_W-1:0]   ch_idx_q,  ch_idx_d;
  logic [COL_W-1:0]  col_idx_q, col_idx_d;
  logic [ROW_W-1:0]  row_idx_q, row_idx_d;
  pool_mode_e        mode_q,    mode_d;
  logic              out_valid_q,  out_valid_d;
  logic [DATA_W-1:0] out_data_q,   out_data_d;
  logic [CH_W-1:0]   out_ch_q,     out_ch_d;
  logic              frame_done_q, frame_done_d;

  // One partial window result per (output column, channel).
  logic [ACC_W-1:0]  buf_q [ENTRIES];

  // --------------------------------------------------------------------------
  // Beat decode
  // --------------------------------------------------------------------------
  logic              w_frame_start;
  pool_mode_e        w_mode;
  logic [LOG_P-1:0]  w_wr;
  logic [LOG_P-1:0]  w_wc;
  logic              w_active;
  logic              w_first;
  logic              w_last;
  logic [IDX_W-1:0]  w_idx;
  logic [ACC_W-1:0]  w_acc;
  logic [ACC_W-1:0]  w_acc_next;
  logic [DATA_W-1:0] w_avg;
  logic [DATA_W-1:0] w_result;

  assign w_frame_start = (ch_idx_q == '0) && (col_idx_q == '0) && (row_idx_q == '0);

  // The frame-start beat is itself pooled, so it must already see the new mode.
  assign w_mode = w_frame_start ? pool_mode_e'(mode) : mode_q;

  assign w_wr = row_idx_q[LOG_P-1:0];
  assign w_wc = col_idx_q[LOG_P-1:0];

  assign w_active = in_valid &&
                    (32'(row_idx_q) < ACT_H) &&
                    (32'(col_idx_q) < ACT_W);

  assign w_first = (w_wr == '0) && (w_wc == '0);
  assign w_last  = (&w_wr) && (&w_wc);

  assign w_idx = IDX_W'(((32'(col_idx_q)) >> LOG_P) * CH + 32'(ch_idx_q));
  assign w_acc = buf_q[w_idx];

  pool_combine #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .SIGNED (SIGNED)
  ) u_combine (
    .mode_i     (w_mode),
    .first_i    (w_first),
    .acc_i      (w_acc),
    .in_i       (in_data),
    .acc_next_o (w_acc_next)
  );

  // Dividing a POOL*POOL sum by a power of two: floor via arithmetic shift
  // for signed data; the quotient always fits back into DATA_W.
  generate
    if (SIGNED) begin : g_avg_signed
      assign w_avg = DATA_W'($signed(w_acc_next) >>> SHIFT);
    end else begin : g_avg_unsigned
      assign w_avg = DATA_W'(w_acc_next >> SHIFT);
    end
  endgenerate

  assign w_result = (w_mode == POOL_AVG) ? w_avg : w_acc_next[DATA_W-1:0];

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    ch_idx_d  = ch_idx_q;
    col_idx_d = col_idx_q;
    row_idx_d = row_idx_q;
    if (in_valid) begin
      if (ch_idx_q == CH_W'(CH - 1)) begin
        ch_idx_d = '0;
        if (col_idx_q == COL_W'(IMG_W - 1)) begin
          col_idx_d = '0;
          if (row_idx_q == ROW_W'(IMG_H - 1)) begin
            row_idx_d = '0;
          end else begin
            row_idx_d = row_idx_q + 1'b1;
          end
        end else begin
          col_idx_d = col_idx_q + 1'b1;
        end
      end else begin
        ch_idx_d = ch_idx_q + 1'b1;
      end
    end
  end

  always_comb begin
    mode_d       = (in_valid && w_frame_start) ? pool_mode_e'(mode) : mode_q;
    out_valid_d  = w_active && w_last;
    out_data_d   = out_data_q;
    out_ch_d     = out_ch_q;
    if (w_active && w_last) begin
      out_data_d = w_result;
      out_ch_d   = ch_idx_q;
    end
    frame_done_d = in_valid &&
                   (ch_idx_q  == CH_W'(CH - 1)) &&
                   (col_idx_q == COL_W'(IMG_W - 1)) &&
                   (row_idx_q == ROW_W'(IMG_H - 1));
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_idx_q     <= '0;
      col_idx_q    <= '0;
      row_idx_q    <= '0;
      mode_q       <= POOL_MAX;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_ch_q     <= '0;
      frame_done_q <= 1'b0;
    end else begin
      ch_idx_q     <= ch_idx_d;
      col_idx_q    <= col_idx_d;
      row_idx_q    <= row_idx_d;
      mode_q       <= mode_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_ch_q     <= out_ch_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Buffer needs no reset: the first beat of every window overwrites its
  // entry, and the window-completing beat consumes it without a write.
  always_ff @(posedge clk) begin
    if (!rst && w_active && !w_last) begin
      buf_q[w_idx] <= w_acc_next;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_ch     = out_ch_q;
  assign frame_done = frame_done_q;

endmodule : pool_unit_gen
`default_nettype wire

// File: tb/tb_pool_unit_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_pool_unit_gen
// Description : Self-checking bench for pool_unit_gen. Three instances:
//               inst0 4x4/CH1 signed, inst1 4x4/CH1 unsigned (shared
//               stimulus), inst2 5x5/CH2 signed. A frame-level model stores
//               the image and computes each window result arithmetically.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pool_unit_gen;

  logic clk;
  logic a_rst, a_mode, a_v;
  logic [7:0] a_d;
  logic b_rst, b_mode, b_v;
  logic [7:0] b_d;

  logic       ov [3];
  logic [7:0] od [3];
  logic [0:0] oc [3];
  logic       fd [3];

  // expectations for the cycle after the driven beat
  logic ev_d [3], ev_q [3], efd_d [3], efd_q [3];
  int   ed_d [3], ed_q [3], ec_d [3], ec_q [3];

  int   k [2];
  int   fmode [2];
  int   img [2][2][5][5];
  int   cap [3][$];
  int   capc [3][$];
  int   n_cmp, n_err;
  logic chk_en;
  int   e8 [8];
  int   pa [4], pb [4];

  pool_unit_gen #(.DATA_W(8), .IMG_W(4), .IMG_H(4), .POOL(2), .CH(1), .SIGNED(1'b1)) u_dut_s (
    .clk(clk), .rst(a_rst), .mode(a_mode), .in_valid(a_v), .in_data(a_d),
    .out_valid(ov[0]), .out_data(od[0]), .out_ch(oc[0]), .frame_done(fd[0]));

  pool_unit_gen #(.DATA_W(8), .IMG_W(4), .IMG_H(4), .POOL(2), .CH(1), .SIGNED(1'b0)) u_dut_u (
    .clk(clk), .rst(a_rst), .mode(a_mode), .in_valid(a_v), .in_data(a_d),
    .out_valid(ov[1]), .out_data(od[1]), .out_ch(oc[1]), .frame_done(fd[1]));

  pool_unit_gen #(.DATA_W(8), .IMG_W(5), .IMG_H(5), .POOL(2), .CH(2), .SIGNED(1'b1)) u_dut_c (
    .clk(clk), .rst(b_rst), .mode(b_mode), .in_valid(b_v), .in_data(b_d),
    .out_valid(ov[2]), .out_data(od[2]), .out_ch(oc[2]), .frame_done(fd[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic chk(input string nm, input int inst, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s inst%0d at %0t: got %0d expected %0d", nm, inst, $time, act, exp);
    end
  endtask

  // Max or floor-average of a 2x2 window, values interpreted per signedness.
  function automatic int model_val(input int sgn, input int m,
                                   input int a, input int b, input int c, input int e);
    int v [4];
    int best, sum;
    v[0] = a; v[1] = b; v[2] = c; v[3] = e;
    for (int i = 0; i < 4; i++) if (sgn != 0 && v[i] > 127) v[i] = v[i] - 256;
    best = v[0];
    sum  = 0;
    for (int i = 0; i < 4; i++) begin
      if (v[i] > best) best = v[i];
      sum = sum + v[i];
    end
    return (m != 0) ? ((sum >>> 2) & 255) : (best & 255);
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      ev_q[i]  <= ev_d[i];
      efd_q[i] <= efd_d[i];
      ed_q[i]  <= ed_d[i];
      ec_q[i]  <= ec_d[i];
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        chk("out_valid", i, int'(ov[i]), int'(ev_q[i]));
        chk("frame_done", i, int'(fd[i]), int'(efd_q[i]));
        if (ev_q[i]) begin
          chk("out_data", i, int'(od[i]), ed_q[i]);
          chk("out_ch", i, int'(oc[i]), ec_q[i]);
        end
        if (ov[i]) begin
          cap[i].push_back(int'(od[i]));
          capc[i].push_back(int'(oc[i]));
        end
      end
    end
  end

  task automatic drive_idle();
    a_rst = 1'b0; b_rst = 1'b0; a_v = 1'b0; b_v = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ev_d[i] = 1'b0; efd_d[i] = 1'b0; ed_d[i] = 0; ec_d[i] = 0;
    end
  endtask

  task automatic gap();
    @(posedge clk); #1;
    drive_idle();
  endtask

  // g=0 drives inst0/inst1, g=1 drives inst2.
  task automatic beat(input int g, input int d, input int m);
    int w, c, ch, col, row;
    @(posedge clk); #1;
    drive_idle();
    w   = (g == 0) ? 4 : 5;
    c   = (g == 0) ? 1 : 2;
    ch  = k[g] % c;
    col = (k[g] / c) % w;
    row = k[g] / (c * w);
    if (k[g] == 0) fmode[g] = m;
    img[g][ch][row][col] = d & 255;
    if (g == 0) begin a_v = 1'b1; a_d = 8'(d); a_mode = m[0]; end
    else        begin b_v = 1'b1; b_d = 8'(d); b_mode = m[0]; end
    for (int i = 0; i < 3; i++) begin
      if ((g == 0 && i < 2) || (g == 1 && i == 2)) begin
        if ((row % 2 == 1) && (col % 2 == 1) && (row < (w / 2) * 2) && (col < (w / 2) * 2)) begin
          ev_d[i] = 1'b1;
          ec_d[i] = ch;
          ed_d[i] = model_val((i != 1) ? 1 : 0, fmode[g],
                              img[g][ch][row-1][col-1], img[g][ch][row-1][col],
                              img[g][ch][row][col-1],   img[g][ch][row][col]);
        end
        if (k[g] == w * w * c - 1) efd_d[i] = 1'b1;
      end
    end
    if (k[g] == w * w * c - 1) k[g] = 0;
    else k[g] = k[g] + 1;
  endtask

  task automatic do_reset(input int g);
    @(posedge clk); #1;
    drive_idle();
    if (g != 1) begin a_rst = 1'b1; k[0] = 0; end
    if (g != 0) begin b_rst = 1'b1; k[1] = 0; end
    @(posedge clk); #1;
    drive_idle();
  endtask

  task automatic clear_caps();
    for (int i = 0; i < 3; i++) begin
      cap[i].delete();
      capc[i].delete();
    end
  endtask

  task automatic check_caps(input string nm, input int inst, input int e [8], input int n);
    chk({nm, "_count"}, inst, cap[inst].size(), n);
    for (int j = 0; j < n; j++) begin
      chk(nm, inst, (j < cap[inst].size()) ? cap[inst][j] : -1, e[j]);
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0; chk_en = 1'b0;
    a_mode = 1'b0; b_mode = 1'b0; a_d = '0; b_d = '0;
    k[0] = 0; k[1] = 0; fmode[0] = 0; fmode[1] = 0;
    drive_idle();
    a_rst = 1'b1; b_rst = 1'b1;
    do_reset(2);
    chk_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_out_data", i, int'(od[i]), 0);
      chk("rst_out_ch", i, int'(oc[i]), 0);
      chk("rst_out_valid", i, int'(ov[i]), 0);
    end

    // Max on a 0..15 ramp
    clear_caps();
    for (int i = 0; i < 16; i++) beat(0, i, 0);
    gap(); gap();
    e8 = '{5, 7, 13, 15, 0, 0, 0, 0};
    check_caps("ramp_max", 0, e8, 4);
    check_caps("ramp_max", 1, e8, 4);

    // 0xF0 everywhere with 0x80 at each window's top-left
    clear_caps();
    for (int i = 0; i < 16; i++) beat(0, (((i / 4) % 2 == 0) && ((i % 4) % 2 == 0)) ? 8'h80 : 8'hF0, 0);
    gap(); gap();
    e8 = '{240, 240, 240, 240, 0, 0, 0, 0};
    check_caps("f0_80_max", 0, e8, 4);
    check_caps("f0_80_max", 1, e8, 4);

    // Window {7F, 80, 00, 01}: signedness decides the winner
    clear_caps();
    pa = '{8'h7F, 8'h80, 8'h00, 8'h01};
    for (int i = 0; i < 16; i++) beat(0, pa[((i / 4) % 2) * 2 + (i % 4) % 2], 0);
    gap(); gap();
    e8 = '{127, 127, 127, 127, 0, 0, 0, 0};
    check_caps("sign_max", 0, e8, 4);
    e8 = '{128, 128, 128, 128, 0, 0, 0, 0};
    check_caps("sign_max", 1, e8, 4);

    // Average: top windows {-1,-2,-3,-3} -> -3, bottom {1,1,1,0} -> 0
    clear_caps();
    pa = '{8'hFF, 8'hFE, 8'hFD, 8'hFD};
    pb = '{1, 1, 1, 0};
    for (int i = 0; i < 16; i++) begin
      if (i < 8) beat(0, pa[((i / 4) % 2) * 2 + (i % 4) % 2], 1);
      else       beat(0, pb[((i / 4) % 2) * 2 + (i % 4) % 2], 1);
    end
    gap(); gap();
    e8 = '{253, 253, 0, 0, 0, 0, 0, 0};
    check_caps("avg_floor", 0, e8, 4);
    check_caps("avg_floor", 1, e8, 4);

    // Mode latched at frame start, flip ignored; back-to-back max frame
    clear_caps();
    for (int i = 0; i < 16; i++) beat(0, i, (i < 6) ? 1 : 0);
    for (int i = 0; i < 16; i++) beat(0, i, 0);
    gap(); gap();
    e8 = '{2, 4, 10, 12, 5, 7, 13, 15};
    check_caps("mode_latch", 0, e8, 8);
    check_caps("mode_latch", 1, e8, 8);

    // Reset after 9 beats, then a clean descending frame
    for (int i = 0; i < 9; i++) beat(0, 200 - i, 0);
    do_reset(0);
    chk("midrst_out_data", 0, int'(od[0]), 0);
    chk("midrst_out_data", 1, int'(od[1]), 0);
    chk("midrst_out_valid", 0, int'(ov[0]), 0);
    clear_caps();
    for (int i = 0; i < 16; i++) beat(0, 15 - i, 0);
    gap(); gap();
    e8 = '{15, 13, 7, 5, 0, 0, 0, 0};
    check_caps("after_rst", 0, e8, 4);

    // 5x5, CH=2, random data with ~30% gaps; one max frame then one avg frame
    clear_caps();
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 50; i++) begin
        if ($urandom_range(0, 99) < 30) gap();
        beat(1, int'($urandom_range(0, 255)), f);
      end
    end
    gap(); gap();
    chk("ch2_count", 2, cap[2].size(), 16);
    for (int j = 0; j < 16; j++) begin
      chk("ch2_out_ch", 2, (j < capc[2].size()) ? capc[2][j] : -1, j % 2);
    end

    gap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_pool_unit_gen
`default_nettype wire
